clean_timer: RTL and testbench
==============================

# clean_timer

Parametrised self-clean sequencer for the range-hood controller. Replaces the fixed 180-cycle cleaner with a real-time countdown: an internal 1 Hz prescaler, a run-time-loadable duration in BCD minutes:seconds, hold/resume and abort. It sits between the mode/keypad FSM, which issues start, hold and abort, and the seven-segment display driver, which consumes the BCD countdown directly.

## Interface
- CLK_HZ, 100_000_000, clock cycles per countdown second; must be ≥ 2. Use 4 in simulation.
- MAX_MM, 8'h99, BCD ceiling applied to the loaded minutes.
- clk  in  1  system clock, all logic on its rising edge.
- rst  in  1  reset, synchronous, active-low.
- start_clean  in  1  start request, sampled only in IDLE.
- dur_mm  in  8  BCD minutes, two digits, latched on an accepted start.
- dur_ss  in  8  BCD seconds, two digits, latched on an accepted start.
- hold  in  1  level signal; while high the countdown freezes.
- abort  in  1  pulse; cancels an active clean.
- cleaning  out  1  high in RUN and HOLD.
- paused  out  1  high in HOLD.
- countdown  out  16  BCD {M tens, M ones, S tens, S ones}.
- done  out  1  one-cycle completion pulse.

## Operation
- States:
  - IDLE: waits for start_clean.
  - RUN: prescaler counts toward the next tick.
  - HOLD: prescaler and digits are frozen.
  - DONE: lasts one cycle, then returns to IDLE.
- Transition priority, highest first: rst, then abort, then hold, then tick.
- IDLE → RUN when start_clean=1 and the loaded value is non-zero:
  - countdown is loaded with the clamped dur_mm:dur_ss.
  - The prescaler is cleared.
- IDLE → DONE when start_clean=1 and the loaded value is 00:00. cleaning is never asserted in this case.
- Load clamping:
  - Each minute digit above 9 is clamped to 9, then the result is limited to MAX_MM.
  - dur_ss above 0x59 is clamped to 0x59.
  - A seconds ones digit above 9 is clamped to 9.
- RUN → HOLD when hold=1. Any tick in that same cycle is discarded.
- HOLD → RUN when hold=0. The prescaler resumes from its frozen phase.
- RUN or HOLD → IDLE when abort=1:
  - countdown freezes at its present value.
  - done is not asserted.
- Decrement rule on each tick in RUN:
  - BCD decrement of MM:SS with borrow; SS wraps from 00 to 59 and borrows one minute.
  - Each digit stays in the range 0–9 at all times.
- RUN → DONE on the tick that takes countdown from 00:01 to 00:00.
- DONE → IDLE unconditionally on the next edge.
- start_clean outside IDLE is ignored, including during DONE.
- countdown holds its last value in IDLE until the next accepted start.

## Timing
- Reset values: state=IDLE, cleaning=0, paused=0, done=0, countdown=16'h0000, prescaler=0.
- All outputs are registered and decoded from the state and digit registers. There is no combinational path from any input to any output.
- Start latency: the edge that samples start_clean leaves cleaning=1 with countdown loaded. The first decrement occurs CLK_HZ cycles after entering RUN.
- Tick: fires when prescaler == CLK_HZ-1 in RUN; the prescaler then reloads to 0.
- Completion: on the edge after the final tick, countdown=0000, cleaning=0 and done=1. On the next edge done=0 and state=IDLE.
- Hold and abort take effect on the first edge they are sampled high.
- A reset asserted mid-clean returns every output to its reset value on that edge.

## Structure
- Package clean_pkg holds:
  - the state enum, as a 2-bit encoding;
  - the BCD digit typedef, 4 bits;
  - the constants SS_WRAP = 8'h59 and the zero time 16'h0000.
- Sub-module sec_tick:
  - Parameter CLK_HZ.
  - Inputs clk, rst, clr, en; output tick.
  - Width is $clog2(CLK_HZ).
- The BCD decrement and clamp logic live in clean_timer.

## Test plan
All scenarios run with CLK_HZ=4.
- Basic countdown: start with 00:03. Required response:
  - cleaning=1 on the next edge;
  - countdown steps 0003 → 0002 → 0001 → 0000 at 4-cycle intervals;
  - done high for exactly 1 cycle, coincident with cleaning falling.
- Borrow: start with 01:00. After 4 cycles countdown = 0059; after a further 4 cycles countdown = 0058.
- Hold: start with 00:05, raise hold for 10 cycles mid-second. Required response:
  - paused=1 and countdown frozen for the whole hold;
  - after release the remaining phase completes and the countdown continues;
  - the total run is 20 RUN cycles.
- Abort with simultaneous hold: start with 00:05, then assert abort and hold together at countdown 0003. Required response:
  - next edge cleaning=0, paused=0, done stays 0, countdown stays 0003;
  - a later start reloads correctly.
- Zero and clamp: start with 00:00, which must give done=1 with cleaning never high. Then start with dur_ss=8'h7A, which must load 0059.
- Reset mid-run: drive rst low at countdown 0002. On that edge all outputs return to 0, and a start in the same cycle is ignored.

Source files
------------

// File: rtl/clean_pkg.sv
// Shared types and constants for the range-hood self-clean countdown timer.
package clean_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam logic [7:0]  SS_WRAP   = 8'h59;
  localparam logic [15:0] ZERO_TIME = 16'h0000;

endpackage

// File: rtl/clean_timer_if.sv
// Control/status bundle between the keypad mode FSM (master) and the clean timer (slave).
interface clean_timer_if;

  logic        start_clean;
  logic [7:0]  dur_mm;
  logic [7:0]  dur_ss;
  logic        hold;
  logic        abort;
  logic        cleaning;
  logic        paused;
  logic [15:0] countdown;
  logic        done;

  modport master (
    output start_clean, dur_mm, dur_ss, hold, abort,
    input  cleaning, paused, countdown, done
  );

  modport slave (
    input  start_clean, dur_mm, dur_ss, hold, abort,
    output cleaning, paused, countdown, done
  );

endinterface

// File: rtl/sec_tick.sv
// Prescaler producing one tick every CLK_HZ enabled cycles; phase is kept while en is low.
module sec_tick #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int              W   = $clog2(CLK_HZ);
  localparam logic [W-1:0]    TOP = W'(CLK_HZ - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == TOP);

  // Prescaler counter: clear on start, advance only when enabled, wrap on the tick.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == TOP) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/clean_timer.sv
// Self-clean sequencer: loads a clamped BCD mm:ss duration and counts it down once per second.
module clean_timer
  import clean_pkg::*;
#(
  parameter int         CLK_HZ = 100_000_000,
  parameter logic [7:0] MAX_MM = 8'h99
) (
  input  logic          clk,
  input  logic          rst,
  clean_timer_if.slave  bus
);

  state_t      state, state_nxt;
  logic [15:0] cd, cd_nxt;
  logic [15:0] ld;
  logic        tick;
  logic        presc_clr;
  logic        presc_en;

  function automatic bcd_t sat_digit(bcd_t d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // Digits saturate first so the MAX_MM compare is a valid BCD magnitude compare.
  function automatic logic [7:0] clamp_mm(logic [7:0] mm);
    logic [7:0] t;
    t = {sat_digit(mm[7:4]), sat_digit(mm[3:0])};
    return (t > MAX_MM) ? MAX_MM : t;
  endfunction

  // Whole-byte ceiling catches illegal tens digits; ones digit is saturated afterwards.
  function automatic logic [7:0] clamp_ss(logic [7:0] ss);
    logic [7:0] t;
    t = (ss > SS_WRAP) ? SS_WRAP : ss;
    return {t[7:4], sat_digit(t[3:0])};
  endfunction

  // One-second BCD decrement of mm:ss with seconds wrapping 00 -> 59.
  function automatic logic [15:0] bcd_dec(logic [15:0] t);
    bcd_t m1, m0, s1, s0;
    {m1, m0, s1, s0} = t;
    if (s0 != 4'd0) begin
      s0 = s0 - 4'd1;
    end else begin
      s0 = 4'd9;
      if (s1 != 4'd0) begin
        s1 = s1 - 4'd1;
      end else begin
        s1 = SS_WRAP[7:4];
        if (m0 != 4'd0) begin
          m0 = m0 - 4'd1;
        end else begin
          m0 = 4'd9;
          if (m1 != 4'd0) m1 = m1 - 4'd1;
        end
      end
    end
    return {m1, m0, s1, s0};
  endfunction

  assign ld       = {clamp_mm(bus.dur_mm), clamp_ss(bus.dur_ss)};
  assign presc_en = (state == ST_RUN);

  sec_tick #(.CLK_HZ(CLK_HZ)) u_sec_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (presc_clr),
    .en   (presc_en),
    .tick (tick)
  );

  // Next-state and countdown update; abort outranks hold, hold outranks the tick.
  always_comb begin
    state_nxt = state;
    cd_nxt    = cd;
    presc_clr = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start_clean) begin
          cd_nxt    = ld;
          presc_clr = 1'b1;
          state_nxt = (ld == ZERO_TIME) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          state_nxt = ST_IDLE;
        end else if (bus.hold) begin
          state_nxt = ST_HOLD;
        end else if (tick) begin
          cd_nxt = bcd_dec(cd);
          if (cd == 16'h0001) state_nxt = ST_DONE;
        end
      end
      ST_HOLD: begin
        if (bus.abort) begin
          state_nxt = ST_IDLE;
        end else if (!bus.hold) begin
          state_nxt = ST_RUN;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and digit registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
      cd    <= ZERO_TIME;
    end else begin
      state <= state_nxt;
      cd    <= cd_nxt;
    end
  end

  assign bus.cleaning  = (state == ST_RUN) || (state == ST_HOLD);
  assign bus.paused    = (state == ST_HOLD);
  assign bus.done      = (state == ST_DONE);
  assign bus.countdown = cd;

endmodule

// File: tb/tb_clean_timer.sv
// Scoreboard bench for clean_timer with a 4-cycle second.
module tb_clean_timer;

  logic clk;
  logic rst;
  int   cyc;
  int   n_cmp;
  int   n_bad;

  typedef struct {
    int          due;
    string       tag;
    logic [18:0] val;
  } sb_ent_t;

  sb_ent_t sb_q[$];

  clean_timer_if bus ();

  clean_timer #(.CLK_HZ(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, want, cyc);
    end
  endtask

  // Expected {countdown, cleaning, paused, done} after edge number 'due'.
  task automatic push(input int due, input string tag, input logic [15:0] cd,
                      input logic cl, input logic pa, input logic dn);
    sb_ent_t e;
    e.due = due;
    e.tag = tag;
    e.val = {cd, cl, pa, dn};
    sb_q.push_back(e);
  endtask

  task automatic step(input int n);
    sb_ent_t e;
    repeat (n) begin
      @(posedge clk);
      cyc++;
      #1;
      while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
        e = sb_q.pop_front();
        check_val(e.tag, {13'd0, bus.countdown, bus.cleaning, bus.paused, bus.done},
                  {13'd0, e.val});
      end
    end
  endtask

  task automatic drive_start(input logic [7:0] mm, input logic [7:0] ss);
    bus.dur_mm      = mm;
    bus.dur_ss      = ss;
    bus.start_clean = 1'b1;
  endtask

  logic [7:0]  cl_mm [3];
  logic [7:0]  cl_ss [3];
  logic [15:0] cl_ex [3];

  initial begin
    int b;
    cyc = 0; n_cmp = 0; n_bad = 0;
    rst = 1'b0;
    bus.start_clean = 1'b0; bus.dur_mm = 8'h00; bus.dur_ss = 8'h00;
    bus.hold = 1'b0; bus.abort = 1'b0;
    cl_mm = '{8'h00, 8'h3C, 8'hAB};
    cl_ss = '{8'h7A, 8'h4C, 8'h5A};
    cl_ex = '{16'h0059, 16'h3949, 16'h9959};

    // reset
    push(1, "reset_a", 16'h0000, 0, 0, 0);
    push(2, "reset_b", 16'h0000, 0, 0, 0);
    push(3, "idle_after_reset", 16'h0000, 0, 0, 0);
    step(2);
    rst = 1'b1;
    step(1);

    // basic 00:03 countdown, plus a start during DONE that must be ignored
    b = cyc;
    drive_start(8'h00, 8'h03);
    push(b + 1,  "basic_load",      16'h0003, 1, 0, 0);
    push(b + 4,  "basic_pre_tick",  16'h0003, 1, 0, 0);
    push(b + 5,  "basic_t1",        16'h0002, 1, 0, 0);
    push(b + 9,  "basic_t2",        16'h0001, 1, 0, 0);
    push(b + 12, "basic_pre_done",  16'h0001, 1, 0, 0);
    push(b + 13, "basic_done",      16'h0000, 0, 0, 1);
    push(b + 14, "basic_ign_start", 16'h0000, 0, 0, 0);
    push(b + 15, "basic_idle",      16'h0000, 0, 0, 0);
    step(1);
    bus.start_clean = 1'b0;
    step(12);
    drive_start(8'h00, 8'h05);
    step(1);
    bus.start_clean = 1'b0;
    step(1);

    // borrow 01:00 -> 00:59 -> 00:58, then abort
    b = cyc;
    drive_start(8'h01, 8'h00);
    push(b + 1,  "borrow_load",  16'h0100, 1, 0, 0);
    push(b + 4,  "borrow_pre",   16'h0100, 1, 0, 0);
    push(b + 5,  "borrow_59",    16'h0059, 1, 0, 0);
    push(b + 8,  "borrow_hold",  16'h0059, 1, 0, 0);
    push(b + 9,  "borrow_58",    16'h0058, 1, 0, 0);
    push(b + 10, "borrow_abort", 16'h0058, 0, 0, 0);
    step(1);
    bus.start_clean = 1'b0;
    step(8);
    bus.abort = 1'b1;
    step(1);
    bus.abort = 1'b0;

    // hold for 10 cycles mid-second; 20 RUN cycles in total
    b = cyc;
    drive_start(8'h00, 8'h05);
    push(b + 1,  "hold_load",     16'h0005, 1, 0, 0);
    push(b + 5,  "hold_t1",       16'h0004, 1, 0, 0);
    push(b + 6,  "hold_pre",      16'h0004, 1, 0, 0);
    push(b + 7,  "hold_enter",    16'h0004, 1, 1, 0);
    push(b + 12, "hold_mid",      16'h0004, 1, 1, 0);
    push(b + 16, "hold_last",     16'h0004, 1, 1, 0);
    push(b + 17, "hold_release",  16'h0004, 1, 0, 0);
    push(b + 18, "hold_phase",    16'h0004, 1, 0, 0);
    push(b + 19, "hold_t2",       16'h0003, 1, 0, 0);
    push(b + 23, "hold_t3",       16'h0002, 1, 0, 0);
    push(b + 27, "hold_t4",       16'h0001, 1, 0, 0);
    push(b + 30, "hold_pre_done", 16'h0001, 1, 0, 0);
    push(b + 31, "hold_done",     16'h0000, 0, 0, 1);
    push(b + 32, "hold_idle",     16'h0000, 0, 0, 0);
    step(1);
    bus.start_clean = 1'b0;
    step(5);
    bus.hold = 1'b1;
    step(10);
    bus.hold = 1'b0;
    step(16);

    // abort together with hold at 00:03, then restart
    b = cyc;
    drive_start(8'h00, 8'h05);
    push(b + 1,  "abort_load",  16'h0005, 1, 0, 0);
    push(b + 5,  "abort_t1",    16'h0004, 1, 0, 0);
    push(b + 9,  "abort_at3",   16'h0003, 1, 0, 0);
    push(b + 10, "abort_take",  16'h0003, 0, 0, 0);
    push(b + 11, "abort_stays", 16'h0003, 0, 0, 0);
    step(1);
    bus.start_clean = 1'b0;
    step(8);
    bus.abort = 1'b1;
    bus.hold  = 1'b1;
    step(1);
    bus.abort = 1'b0;
    bus.hold  = 1'b0;
    step(1);
    b = cyc;
    drive_start(8'h00, 8'h02);
    push(b + 1,  "restart_load", 16'h0002, 1, 0, 0);
    push(b + 5,  "restart_t1",   16'h0001, 1, 0, 0);
    push(b + 9,  "restart_done", 16'h0000, 0, 0, 1);
    push(b + 10, "restart_idle", 16'h0000, 0, 0, 0);
    step(1);
    bus.start_clean = 1'b0;
    step(9);

    // zero duration goes straight to DONE
    b = cyc;
    drive_start(8'h00, 8'h00);
    push(b + 1, "zero_done", 16'h0000, 0, 0, 1);
    push(b + 2, "zero_idle", 16'h0000, 0, 0, 0);
    step(1);
    bus.start_clean = 1'b0;
    step(1);

    // load clamping
    for (int i = 0; i < 3; i++) begin
      b = cyc;
      drive_start(cl_mm[i], cl_ss[i]);
      push(b + 1, $sformatf("clamp_load_%0d", i), cl_ex[i], 1, 0, 0);
      push(b + 2, $sformatf("clamp_abort_%0d", i), cl_ex[i], 0, 0, 0);
      step(1);
      bus.start_clean = 1'b0;
      bus.abort = 1'b1;
      step(1);
      bus.abort = 1'b0;
    end

    // reset mid-run with a concurrent start
    b = cyc;
    drive_start(8'h00, 8'h03);
    push(b + 1, "rstrun_load",   16'h0003, 1, 0, 0);
    push(b + 5, "rstrun_t1",     16'h0002, 1, 0, 0);
    push(b + 6, "rstrun_reset",  16'h0000, 0, 0, 0);
    push(b + 7, "rstrun_idle",   16'h0000, 0, 0, 0);
    step(1);
    bus.start_clean = 1'b0;
    step(4);
    rst = 1'b0;
    drive_start(8'h00, 8'h05);
    step(1);
    rst = 1'b1;
    bus.start_clean = 1'b0;
    step(1);

    step(2);
    check_val("sb_drain", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
